fetch_inst_queue: RTL

//  Decoupling FIFO between fetch and decode.
//  - Accepts up to IN_WIDTH fetchEntry_t per cycle from the fetch stage.
//  - Presents up to OUT_WIDTH oldest entries, in program order, to decode.
//  - Flushes completely on a squash from the ROB (squashInfo_t path).

---
 rtl/fetch_inst_queue_pkg.sv | 14 +
 rtl/fetch_inst_queue_lane_popcount.sv | 19 +
 rtl/fetch_inst_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and default sizing for the fetch-to-decode instruction queue.
// Optional same-cycle bypass is selected with the FETCHQ_BYPASS_EN macro.
package fetch_inst_queue_pkg;

    localparam int FETCHQ_DEPTH     = 16;
    localparam int FETCHQ_IN_WIDTH  = 4;
    localparam int FETCHQ_OUT_WIDTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_inst_queue_lane_popcount.sv
// Counts the set bits of a lane valid mask.
// Shared by the multi-lane pipeline stages.
module lane_popcount #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]             i_vec,
    output logic [$clog2(WIDTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + CW'(i_vec[i]);
        end
    end

endmodule

// File: rtl/fetch_inst_queue.sv
// Ring-buffer FIFO decoupling fetch from decode, flushed completely on squash.
// Define FETCHQ_BYPASS_EN to let an empty queue forward incoming lanes in the same cycle.
import fetch_inst_queue_pkg::*;

module fetch_inst_queue #(
    parameter int DEPTH     = FETCHQ_DEPTH,
    parameter int IN_WIDTH  = FETCHQ_IN_WIDTH,
    parameter int OUT_WIDTH = FETCHQ_OUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_squash,
    input  logic [IN_WIDTH-1:0]           i_enq_vld,
    input  fetchEntry_t [IN_WIDTH-1:0]    i_enq_inst,
    output logic                          o_enq_rdy,
    output logic [OUT_WIDTH-1:0]          o_deq_vld,
    output fetchEntry_t [OUT_WIDTH-1:0]   o_deq_inst,
    input  logic                          i_deq_rdy,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(IN_WIDTH + 1);

    fetchEntry_t    r_mem [DEPTH];
    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    logic [CW-1:0]  r_count;

    logic [NW-1:0]  w_n_enq;
    logic [CW-1:0]  w_n_in;
    logic [CW-1:0]  w_skip;
    logic [CW-1:0]  w_n_wr;
    logic [CW-1:0]  w_deq_avail;
    logic [CW-1:0]  w_n_deq;
    logic           w_enq_fire;
    logic           w_deq_fire;

    lane_popcount #(.WIDTH(IN_WIDTH)) u_enq_popcount (
        .i_vec   (i_enq_vld),
        .o_count (w_n_enq)
    );

    assign w_n_in      = CW'(w_n_enq);
    // Ready looks only at registered occupancy, so there is no dequeue-to-enqueue comb path.
    assign o_enq_rdy   = (CW'(DEPTH) - r_count) >= CW'(IN_WIDTH);
    assign w_enq_fire  = o_enq_rdy && (|i_enq_vld) && !i_squash;
    assign w_deq_fire  = i_deq_rdy && (r_count != '0) && !i_squash;
    assign w_deq_avail = (r_count > CW'(OUT_WIDTH)) ? CW'(OUT_WIDTH) : r_count;
    assign w_n_deq     = w_deq_fire ? w_deq_avail : '0;

`ifdef FETCHQ_BYPASS_EN
    logic w_byp_active;
    assign w_byp_active = (r_count == '0) && !i_squash;
    // Lanes decode takes straight off the bypass are never written into storage.
    assign w_skip = (w_byp_active && i_deq_rdy)
                  ? ((w_n_in > CW'(OUT_WIDTH)) ? CW'(OUT_WIDTH) : w_n_in)
                  : '0;
`else
    assign w_skip = '0;
`endif

    assign w_n_wr = w_enq_fire ? (w_n_in - w_skip) : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (w_enq_fire && (CW'(i) >= w_skip) && (CW'(i) < w_n_in)) begin
                r_mem[r_tail + PW'(CW'(i) - w_skip)] <= i_enq_inst[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + PW'(w_n_wr);
            r_head  <= r_head + PW'(w_n_deq);
            r_count <= r_count + w_n_wr - w_n_deq;
        end
    end

    always_comb begin
        o_deq_vld  = '0;
        o_deq_inst = '0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            o_deq_vld[k]  = CW'(k) < r_count;
            o_deq_inst[k] = r_mem[r_head + PW'(k)];
        end
`ifdef FETCHQ_BYPASS_EN
        if (w_byp_active) begin
            for (int k = 0; k < OUT_WIDTH && k < IN_WIDTH; k++) begin
                o_deq_vld[k]  = CW'(k) < w_n_in;
                o_deq_inst[k] = i_enq_inst[k];
            end
        end
`endif
    end

    assign o_count = r_count;

    // Fetch must present valid lanes packed from lane 0.
    always_ff @(posedge clk) begin
        if (rst && !i_squash) begin
            assert ((i_enq_vld & (i_enq_vld + IN_WIDTH'(1))) == '0);
        end
    end

endmodule
